gpu_frame_writer: RTL and testbench
===================================

# gpu_frame_writer

GPU-side frame renderer: the producer end of the double-buffered frame path. It answers `gpu_start` from the frame director, streams pixel writes (`gpu_x`, `gpu_y`, `gpu_data`, `gpu_we`) into the back buffer, then raises `gpu_done` so the director can swap on the next vertical sync. Each frame is a full background clear followed by one clipped filled rectangle. It runs in the 150 MHz GPU clock domain.

## Interface
- `H_RES`, default 320: frame width in pixels.
- `V_RES`, default 240: frame height in pixels.
- `clk`  in  1  GPU clock, 150 MHz, the same clock as the frame buffer write port.
- `reset`  in  1  asynchronous, active-low reset.
- `gpu_start`  in  1  render request from the frame director. Asynchronous to `clk` and level-held until `gpu_done` falls.
- `bg_color`  in  4  background grey level. Latched at frame start.
- `rect_x0`, `rect_y0`, `rect_x1`, `rect_y1`  in  10 each  inclusive rectangle corners. Latched at frame start.
- `rect_color`  in  4  rectangle grey level. Latched at frame start.
- `gpu_x`, `gpu_y`  out  10 each  pixel coordinate of the current write.
- `gpu_data`  out  4  pixel value of the current write.
- `gpu_we`  out  1  write strobe, one pixel per cycle.
- `gpu_done`  out  1  high while the back buffer is complete and idle.
- `frame_count`  out  16  number of completed frames. Wraps modulo 2^16.

## Operation
- `gpu_start` passes through a 2-flop synchronizer; the synchronized signal is `start_s`. No other input is synchronized, because the parameter inputs are quasi-static.
- States: DONE, CLEAR, RECT, FINISH.
- **Reset** (while `reset`=0): state DONE, `gpu_done`=1, `gpu_we`=0, `gpu_x`=`gpu_y`=0, `gpu_data`=0, `frame_count`=0.
  - `gpu_done`=1 at reset lets the director issue the first start on its first vsync.
- **DONE**
  - `start_s`=1: latch all parameter inputs, drop `gpu_done`, go to CLEAR.
  - Otherwise hold, with `gpu_we`=0.
- **CLEAR**
  - Raster sweep: x runs 0..H_RES-1 inner, y runs 0..V_RES-1 outer.
  - One write per cycle, `gpu_data`=latched `bg_color`.
  - After pixel (H_RES-1, V_RES-1): go to RECT if the rectangle is valid, else to FINISH.
- **Rectangle clipping**
  - cx1 = min(rect_x1, H_RES-1) and cy1 = min(rect_y1, V_RES-1).
  - Valid only if rect_x0 ≤ cx1 and rect_y0 ≤ cy1.
  - An empty or fully off-screen rectangle (rect_x0 ≥ H_RES or rect_y0 ≥ V_RES) is skipped.
- **RECT**
  - Raster sweep: x runs rect_x0..cx1, y runs rect_y0..cy1.
  - `gpu_data`=latched `rect_color`, one write per cycle.
  - After the last pixel: go to FINISH.
- **FINISH**
  - `gpu_we`=0.
  - Wait for `start_s`=0. The director clears `gpu_start` only after seeing `gpu_done` low; this wait prevents one stale start from rendering twice.
  - Then: `gpu_done`<=1, `frame_count`<=`frame_count`+1, go to DONE.
- Coordinate counters are 10-bit unsigned and never exceed H_RES-1 or V_RES-1. No write ever targets an out-of-frame address.
- `reset` asserted mid-frame aborts immediately to the reset values. The partial frame is discarded and `gpu_done`=1.

## Timing
- All outputs are registered.
- `gpu_start` rising to `start_s` high: 2–3 `clk` edges.
- On the edge where DONE sees `start_s`=1, all of these happen together:
  - `gpu_done` falls;
  - `gpu_we`=1;
  - `gpu_x`=`gpu_y`=0;
  - `gpu_data`=`bg_color`.
- CLEAR takes exactly H_RES×V_RES write cycles.
- RECT directly follows the last CLEAR write, with no bubble. It takes (cx1−rect_x0+1)×(cy1−rect_y0+1) cycles.
- The edge after the last write sets `gpu_we`=0 and enters FINISH.
- If `start_s` is already 0, `gpu_done` rises one edge later.
- Line wrap (x back to its start value, y+1) happens on a single edge, with no idle cycle.
- Parameter changes after the latch edge do not affect the frame in progress.

## Test plan
- Reset check, H_RES=8, V_RES=4: hold `reset`=0 → `gpu_done`=1, `gpu_we`=0, `frame_count`=0. Release reset with `gpu_start`=0 → no writes occur.
- Clear only, `bg_color`=4'h3, rect (9,0,9,0) off-screen:
  - pulse-hold `gpu_start` until `gpu_done` falls;
  - expect exactly 32 writes of 4'h3, in order (0,0),(1,0)…(7,3);
  - then `gpu_done`=1 and `frame_count`=1.
- Clipped rectangle, `rect_color`=4'hF, rect (6,2,20,9):
  - after 32 clear writes, expect 4 writes: (6,2),(7,2),(6,3),(7,3), all 4'hF.
- Inverted rectangle (5,1,2,3) → no RECT writes; `gpu_done` rises one edge after FINISH.
- Stale start: keep `gpu_start` high for the whole frame → the block stays in FINISH with `gpu_done`=0. Drop `gpu_start` → `gpu_done` rises 3–4 edges later; there is no second render.
- Mid-frame reset: assert `reset` during CLEAR at pixel (3,1) → `gpu_we`=0 and `gpu_done`=1 immediately. A new start then restarts the sweep at (0,0).

Source files
------------

// File: rtl/gpu_frame_writer_if.sv
// Frame path bus between the GPU writer, the frame director and the back-buffer write port.
interface gpu_frame_writer_if;
   logic       gpu_start;
   logic       gpu_done;
   logic [9:0] gpu_x;
   logic [9:0] gpu_y;
   logic [3:0] gpu_data;
   logic       gpu_we;

   modport master (
      input  gpu_start,
      output gpu_done,
      output gpu_x,
      output gpu_y,
      output gpu_data,
      output gpu_we
   );

   modport slave (
      output gpu_start,
      input  gpu_done,
      input  gpu_x,
      input  gpu_y,
      input  gpu_data,
      input  gpu_we
   );
endinterface

// File: rtl/gpu_frame_writer.sv
// Back-buffer renderer: full-screen clear followed by one clipped filled rectangle per frame.
module gpu_frame_writer #(
   parameter int unsigned H_RES = 320,
   parameter int unsigned V_RES = 240
) (
   input  logic                 clk,
   input  logic                 reset,
   gpu_frame_writer_if.master   fb,
   input  logic [3:0]           bg_color,
   input  logic [9:0]           rect_x0,
   input  logic [9:0]           rect_y0,
   input  logic [9:0]           rect_x1,
   input  logic [9:0]           rect_y1,
   input  logic [3:0]           rect_color,
   output logic [15:0]          frame_count
);

   localparam logic [9:0] XMax = 10'(H_RES - 1);
   localparam logic [9:0] YMax = 10'(V_RES - 1);

   typedef enum logic [1:0] {StDone, StClear, StRect, StFinish} state_e;

   state_e      state_q, state_d;
   logic        start_meta_q, start_s_q;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [3:0]  data_q, data_d;
   logic        we_q, we_d;
   logic        done_q, done_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  rect_color_q, rect_color_d;
   logic [9:0]  x0_q, x0_d, y0_q, y0_d, cx1_q, cx1_d, cy1_q, cy1_d;
   logic        valid_q, valid_d;

   logic [9:0]  clip_x1, clip_y1;

   // Clip against the frame edges so every write lands inside the buffer.
   assign clip_x1 = (rect_x1 > XMax) ? XMax : rect_x1;
   assign clip_y1 = (rect_y1 > YMax) ? YMax : rect_y1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_meta_q <= 1'b0;
         start_s_q    <= 1'b0;
      end else begin
         start_meta_q <= fb.gpu_start;
         start_s_q    <= start_meta_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StDone;
         x_q          <= '0;
         y_q          <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         done_q       <= 1'b1;
         count_q      <= '0;
         rect_color_q <= '0;
         x0_q         <= '0;
         y0_q         <= '0;
         cx1_q        <= '0;
         cy1_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         data_q       <= data_d;
         we_q         <= we_d;
         done_q       <= done_d;
         count_q      <= count_d;
         rect_color_q <= rect_color_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         cx1_q        <= cx1_d;
         cy1_q        <= cy1_d;
         valid_q      <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      data_d       = data_q;
      we_d         = we_q;
      done_d       = done_q;
      count_d      = count_q;
      rect_color_d = rect_color_q;
      x0_d         = x0_q;
      y0_d         = y0_q;
      cx1_d        = cx1_q;
      cy1_d        = cy1_q;
      valid_d      = valid_q;

      unique case (state_q)
         StDone: begin
            we_d = 1'b0;
            if (start_s_q) begin
               rect_color_d = rect_color;
               x0_d         = rect_x0;
               y0_d         = rect_y0;
               cx1_d        = clip_x1;
               cy1_d        = clip_y1;
               valid_d      = (rect_x0 <= clip_x1) && (rect_y0 <= clip_y1);
               done_d       = 1'b0;
               we_d         = 1'b1;
               x_d          = '0;
               y_d          = '0;
               data_d       = bg_color;
               state_d      = StClear;
            end
         end
         StClear: begin
            if (x_q == XMax) begin
               if (y_q == YMax) begin
                  if (valid_q) begin
                     x_d     = x0_q;
                     y_d     = y0_q;
                     data_d  = rect_color_q;
                     state_d = StRect;
                  end else begin
                     we_d    = 1'b0;
                     state_d = StFinish;
                  end
               end else begin
                  x_d = '0;
                  y_d = y_q + 10'd1;
               end
            end else begin
               x_d = x_q + 10'd1;
            end
         end
         StRect: begin
            if (x_q == cx1_q) begin
               if (y_q == cy1_q) begin
                  we_d    = 1'b0;
                  state_d = StFinish;
               end else begin
                  x_d = x0_q;
                  y_d = y_q + 10'd1;
               end
            end else begin
               x_d = x_q + 10'd1;
            end
         end
         StFinish: begin
            we_d = 1'b0;
            // Hold until the director withdraws start so one request renders once.
            if (!start_s_q) begin
               done_d  = 1'b1;
               count_d = count_q + 16'd1;
               state_d = StDone;
            end
         end
         default: state_d = StDone;
      endcase
   end

   assign fb.gpu_x     = x_q;
   assign fb.gpu_y     = y_q;
   assign fb.gpu_data  = data_q;
   assign fb.gpu_we    = we_q;
   assign fb.gpu_done  = done_q;
   assign frame_count  = count_q;

endmodule

// File: tb/tb_gpu_frame_writer.sv
// Self-checking bench for gpu_frame_writer on an 8x4 frame against a raster-order write model.
module tb_gpu_frame_writer;
   localparam int H = 8;
   localparam int V = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  bg_color, rect_color;
   logic [9:0]  rect_x0, rect_y0, rect_x1, rect_y1;
   logic [15:0] frame_count;

   gpu_frame_writer_if bus ();

   gpu_frame_writer #(.H_RES(H), .V_RES(V)) dut (
      .clk         (clk),
      .reset       (reset),
      .fb          (bus.master),
      .bg_color    (bg_color),
      .rect_x0     (rect_x0),
      .rect_y0     (rect_y0),
      .rect_x1     (rect_x1),
      .rect_y1     (rect_y1),
      .rect_color  (rect_color),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int fc_model = 0;

   logic [23:0] got[$];

   always @(negedge clk) begin
      if (bus.gpu_we) got.push_back({bus.gpu_x, bus.gpu_y, bus.gpu_data});
   end

   typedef struct {
      logic [3:0] bg;
      logic [9:0] x0, y0, x1, y1;
      logic [3:0] rc;
      int         n;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input logic [3:0] bg, input logic [9:0] x0, input logic [9:0] y0,
                            input logic [9:0] x1, input logic [9:0] y1, input logic [3:0] rc,
                            input int exp_n, input bit hold);
      logic [23:0] exp_q[$];
      int          cx1, cy1, bad;
      bit          seen;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) exp_q.push_back({10'(x), 10'(y), bg});
      cx1 = (int'(x1) > H - 1) ? H - 1 : int'(x1);
      cy1 = (int'(y1) > V - 1) ? V - 1 : int'(y1);
      for (int y = int'(y0); y <= cy1; y++)
         for (int x = int'(x0); x <= cx1; x++) exp_q.push_back({10'(x), 10'(y), rc});

      @(negedge clk);
      got.delete();
      bg_color = bg; rect_x0 = x0; rect_y0 = y0; rect_x1 = x1; rect_y1 = y1; rect_color = rc;
      bus.gpu_start = 1'b1;

      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.gpu_done) begin seen = 1'b1; break; end
      end
      check("start_ack", seen, seen, 1);
      if (!seen) begin bus.gpu_start = 1'b0; return; end
      check("first_write", bus.gpu_we && bus.gpu_x == 0 && bus.gpu_y == 0 && bus.gpu_data == bg,
            {bus.gpu_we, bus.gpu_x, bus.gpu_y, bus.gpu_data}, {1'b1, 20'd0, bg});

      // Parameters move after the latch edge; the frame must not notice.
      bg_color = 4'($urandom); rect_color = 4'($urandom);
      rect_x0 = 10'($urandom_range(0, 15)); rect_y0 = 10'($urandom_range(0, 15));
      rect_x1 = 10'($urandom_range(0, 15)); rect_y1 = 10'($urandom_range(0, 15));
      if (!hold) bus.gpu_start = 1'b0;

      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.gpu_we) begin seen = 1'b1; break; end
      end
      check("burst_end", seen, seen, 1);
      check("finish_done_low", bus.gpu_done == 1'b0, bus.gpu_done, 0);

      check("write_count", got.size() == exp_q.size(), got.size(), exp_q.size());
      bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] != exp_q[i]) begin bad = i; break; end
      check("write_seq", bad < 0, (bad < 0) ? 0 : got[bad], (bad < 0) ? 0 : exp_q[bad]);
      if (exp_n >= 0) check("table_count", got.size() == exp_n, got.size(), exp_n);

      if (!hold) begin
         @(negedge clk);
         check("done_rise", bus.gpu_done == 1'b1, bus.gpu_done, 1);
         fc_model++;
         check("frame_count", frame_count == 16'(fc_model), frame_count, fc_model);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat, sz;
      bit  ok, seen;

      tbl[0] = '{bg: 4'h3, x0: 10'd9, y0: 10'd0, x1: 10'd9,  y1: 10'd0, rc: 4'hA, n: 32};
      tbl[1] = '{bg: 4'h1, x0: 10'd6, y0: 10'd2, x1: 10'd20, y1: 10'd9, rc: 4'hF, n: 36};
      tbl[2] = '{bg: 4'h5, x0: 10'd5, y0: 10'd1, x1: 10'd2,  y1: 10'd3, rc: 4'h9, n: 32};
      tbl[3] = '{bg: 4'h0, x0: 10'd7, y0: 10'd3, x1: 10'd7,  y1: 10'd3, rc: 4'hC, n: 33};
      tbl[4] = '{bg: 4'h8, x0: 10'd0, y0: 10'd0, x1: 10'd7,  y1: 10'd3, rc: 4'h2, n: 64};
      tbl[5] = '{bg: 4'h6, x0: 10'd0, y0: 10'd4, x1: 10'd7,  y1: 10'd9, rc: 4'h4, n: 32};

      reset = 1'b0;
      bus.gpu_start = 1'b0;
      bg_color = '0; rect_color = '0;
      rect_x0 = '0; rect_y0 = '0; rect_x1 = '0; rect_y1 = '0;
      repeat (3) @(negedge clk);
      check("reset_done", bus.gpu_done == 1'b1, bus.gpu_done, 1);
      check("reset_we", bus.gpu_we == 1'b0, bus.gpu_we, 0);
      check("reset_fc", frame_count == 16'd0, frame_count, 0);
      check("reset_xyd", {bus.gpu_x, bus.gpu_y, bus.gpu_data} == 24'd0,
            {bus.gpu_x, bus.gpu_y, bus.gpu_data}, 0);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_no_writes", got.size() == 0, got.size(), 0);
      check("idle_done", bus.gpu_done == 1'b1, bus.gpu_done, 1);

      for (int i = 0; i < 6; i++)
         run_frame(tbl[i].bg, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].rc, tbl[i].n, 1'b0);

      // Stale start: request held through the whole frame.
      run_frame(4'hD, 10'd1, 10'd1, 10'd2, 10'd2, 4'h7, 36, 1'b1);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.gpu_done) ok = 1'b0;
      end
      check("stale_hold", ok, !ok, 0);
      bus.gpu_start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.gpu_done) begin lat = i; break; end
      end
      check("stale_release_lat", lat >= 3 && lat <= 4, lat, 3);
      fc_model++;
      check("stale_fc", frame_count == 16'(fc_model), frame_count, fc_model);
      sz = got.size();
      repeat (15) @(negedge clk);
      check("no_second_render", got.size() == sz && bus.gpu_done, got.size(), sz);

      // Mid-frame reset at pixel (3,1).
      @(negedge clk);
      bg_color = 4'hE; rect_x0 = 10'd9; rect_y0 = 10'd9; rect_x1 = 10'd9; rect_y1 = 10'd9;
      bus.gpu_start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.gpu_we && bus.gpu_x == 10'd3 && bus.gpu_y == 10'd1) begin seen = 1'b1; break; end
      end
      check("reach_3_1", seen, seen, 1);
      reset = 1'b0;
      bus.gpu_start = 1'b0;
      #1;
      check("abort_we", bus.gpu_we == 1'b0, bus.gpu_we, 0);
      check("abort_done", bus.gpu_done == 1'b1, bus.gpu_done, 1);
      check("abort_fc", frame_count == 16'd0, frame_count, 0);
      fc_model = 0;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      run_frame(4'hB, 10'd2, 10'd0, 10'd3, 10'd0, 4'h1, 34, 1'b0);

      for (int i = 0; i < 20; i++)
         run_frame(4'($urandom), 10'($urandom_range(0, 11)), 10'($urandom_range(0, 6)),
                   10'($urandom_range(0, 11)), 10'($urandom_range(0, 6)), 4'($urandom), -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
